// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: FSM states, legal-function check and wide-to-byte opcode mapping for alu_mp_sequencer
package alu_seq_pkg;
`include "defines.sv"
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  function automatic logic fn_legal(input logic [3:0] fn);
    return fn inside {`ADD_FN, `SUB_FN, `AND_FN, `OR_FN, `XOR_FN, `MASK_FN};
  endfunction
  // Every byte of a wide add/sub must consume the chained carry, so use the carry-in variants.
  function automatic logic [3:0] alu_fn_map(input logic [3:0] fn);
    return fn == `ADD_FN ? `ADDC_FN : fn == `SUB_FN ? `SUBC_FN : fn;
  endfunction
endpackage

// File: rtl/defines.sv
// defines: Alu function codes shared by the control path, the Alu and the sequencer
`ifndef DEFINES_SV
`define DEFINES_SV
`define ADD_FN        4'd0
`define SUB_FN        4'd1
`define AND_FN        4'd2
`define OR_FN         4'd3
`define XOR_FN        4'd4
`define MASK_FN       4'd5
`define ADDC_FN       4'd6
`define SUBC_FN       4'd7
`define ADD_SIGNED_FN 4'd8
`endif

// File: rtl/alu_mp_sequencer.sv
// alu_mp_sequencer: runs one NBYTES-wide op through the shared 8-bit Alu, one byte per cycle, LSB first
//   req_*  : request handshake, operands, function code and carry-in (sampled only in IDLE)
//   rsp_*  : wide result with carry/borrow, accumulated zero and unsupported-function error
//   alu_*  : byte lanes, carry and opcode to the external Alu, and its combinational result/flags
import alu_seq_pkg::*;
module alu_mp_sequencer #(
  parameter  int NBYTES = 4,
  localparam int W      = 8 * NBYTES,
  localparam int IW     = $clog2(NBYTES)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [3:0]   req_fn,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  input  logic         req_cin,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_data,
  output logic         rsp_cout,
  output logic         rsp_zero,
  output logic         rsp_err,
  output logic [7:0]   alu_in1,
  output logic [7:0]   alu_in2,
  output logic         alu_cin,
  output logic [3:0]   alu_opcode,
  input  logic [7:0]   alu_out,
  input  logic         alu_cout,
  input  logic         alu_z
);
  state_t state, nxt;
  logic [W-1:0] a, b, data;
  logic [3:0] fn;
  logic [IW-1:0] idx;
  logic cin, carry, zacc, err;
  logic exec, arith, last;
  assign exec  = state == EXEC;
  assign arith = fn == `ADD_FN || fn == `SUB_FN;
  assign last  = idx == IW'(NBYTES - 1);
  assign req_ready = state == IDLE;
  assign rsp_valid = state == RESP;
  assign rsp_data  = data;
  // Error responses carry no flags; logic ops never report a carry.
  assign rsp_cout  = carry & arith & ~err;
  assign rsp_zero  = zacc & ~err;
  assign rsp_err   = err;
  always_comb begin
    nxt        = state;
    alu_in1    = '0;
    alu_in2    = '0;
    alu_cin    = 1'b0;
    alu_opcode = `ADD_FN;
    nxt = state == IDLE ? (req_valid ? (fn_legal(req_fn) ? EXEC : RESP) : IDLE)
        : state == EXEC ? (last ? RESP : EXEC)
        : (rsp_ready ? IDLE : RESP);
    if (exec) begin
      alu_in1    = a[idx*8 +: 8];
      alu_in2    = b[idx*8 +: 8];
      alu_cin    = arith ? (idx == '0 ? cin : carry) : 1'b0;
      alu_opcode = alu_fn_map(fn);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a     <= '0;
      b     <= '0;
      fn    <= `ADD_FN;
      cin   <= 1'b0;
      idx   <= '0;
      carry <= 1'b0;
      zacc  <= 1'b0;
      data  <= '0;
      err   <= 1'b0;
    end else begin
      state <= nxt;
      if (req_ready && req_valid) begin
        a     <= req_a;
        b     <= req_b;
        fn    <= req_fn;
        cin   <= req_cin;
        idx   <= '0;
        carry <= 1'b0;
        zacc  <= 1'b1;
        data  <= '0;
        err   <= ~fn_legal(req_fn);
      end else if (exec) begin
        data[idx*8 +: 8] <= alu_out;
        carry <= alu_cout;
        zacc  <= zacc & alu_z;
        idx   <= idx + 1'b1;
      end
    end
  end
endmodule
